// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM encoding, frame field
// sizes and the word-address helper.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } loader_state_t;

    localparam int         LEN_BYTES      = 2;
    localparam int         BYTES_PER_WORD = 4;
    localparam logic [7:0] CHK_INIT       = 8'h00;

    // Byte address of word idx; the index is a word count, so shift by two.
    function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                   input logic [15:0] idx);
        return base + {14'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Collects bytes little-endian into a 32-bit word; word_valid pulses together
// with the byte that completes the word.
module byte_word_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] shift_q,    shift_d;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        if (clear) begin
            byte_cnt_d = 2'd0;
            shift_d    = 32'h0;
        end else if (byte_valid) begin
            // New bytes enter at the top so the first byte ends up in [7:0].
            shift_d    = {byte_data, shift_q[31:8]};
            byte_cnt_d = byte_cnt_q + 2'd1;
        end
    end

    assign word_valid = byte_valid && !clear && (byte_cnt_q == LAST_BYTE);
    assign word       = {byte_data, shift_q[31:8]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt_q <= 2'd0;
            shift_q    <= 32'h0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Receives a length-prefixed, XOR-checked program image as a byte stream and
// writes it word by word into program memory while holding the core in reset.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] mem_byte_address,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [2:0]  dbg_state
);

    // Handshake: a byte moves when in_valid && in_ready are high at a rising
    // edge; in_ready depends only on state, never on in_valid.

    localparam int          LEN_W   = 8 * LEN_BYTES;
    localparam logic [16:0] MAX_LEN = 17'(MEM_WORDS);

    loader_state_t     state_q, state_d;
    logic [LEN_W-1:0]  len_q,   len_d;
    logic [15:0]       idx_q,   idx_d;
    logic [7:0]        chk_q,   chk_d;
    logic              we_q,    we_d;
    logic [31:0]       addr_q,  addr_d;
    logic [31:0]       data_q,  data_d;

    logic              accept;
    logic              pk_clear;
    logic              pk_valid;
    logic              word_valid;
    logic [31:0]       word;
    logic [LEN_W-1:0]  len_full;

    assign in_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                      (state_q == ST_DATA)   || (state_q == ST_CHECK);
    assign accept   = in_valid && in_ready;
    assign pk_valid = accept && (state_q == ST_DATA);
    assign len_full = {in_data, len_q[7:0]};

    byte_word_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (pk_clear),
        .byte_valid (pk_valid),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        chk_d    = chk_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        pk_clear = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (load_start) begin
                    state_d  = ST_LEN_LO;
                    len_d    = '0;
                    idx_d    = 16'h0;
                    chk_d    = CHK_INIT;
                    pk_clear = 1'b1;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d   = {8'h00, in_data};
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == '0) begin
                        state_d = ST_CHECK;
                    end else if ({1'b0, len_full} > MAX_LEN) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    chk_d = chk_q ^ in_data;
                end
                // Write strobe, address and data are registered together so
                // they appear one cycle after the word's last byte.
                if (word_valid) begin
                    we_d   = 1'b1;
                    addr_d = word_byte_addr(BASE_ADDR, idx_q);
                    data_d = word;
                    idx_d  = idx_q + 16'd1;
                    if (idx_q == len_q - 16'd1) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    state_d = (in_data == chk_q) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The core stays held through an error so a bad image never runs.
    assign cpu_hold   = in_ready || (state_q == ST_ERROR);
    assign load_done  = (state_q == ST_DONE);
    assign load_error = (state_q == ST_ERROR);
    assign dbg_state  = state_q;

    assign mem_write_enable = we_q;
    assign mem_byte_address = addr_q;
    assign mem_write_data   = data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= 16'h0;
            chk_q   <= CHK_INIT;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framed loads, checksum and length errors,
// zero-length frame, gapped stream and asynchronous reset mid-load.
module tb_program_loader;
    import program_loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mem_byte_address;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [2:0]  dbg_state;

    int tests = 0;
    int fails = 0;

    logic [7:0]  stim_q[$];
    logic [31:0] exp_q[$];

    program_loader dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .load_start       (load_start),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .mem_byte_address (mem_byte_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .cpu_hold         (cpu_hold),
        .load_done        (load_done),
        .load_error       (load_error),
        .dbg_state        (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_we"},       32'(mem_write_enable), 32'd0);
        check({tag, "_addr"},     mem_byte_address, 32'h0);
        check({tag, "_data"},     mem_write_data, 32'h0);
        check({tag, "_hold"},     32'(cpu_hold), 32'd0);
        check({tag, "_done"},     32'(load_done), 32'd0);
        check({tag, "_error"},    32'(load_error), 32'd0);
    endtask

    // Drivers
    task automatic load_pulse();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("start_hold", 32'(cpu_hold), 32'd1);
        check("start_ready", 32'(in_ready), 32'd1);
        check("start_error", 32'(load_error), 32'd0);
    endtask

    task automatic idle_in_load();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
        check("gap_ready", 32'(in_ready), 32'd1);
        check("gap_we", 32'(mem_write_enable), 32'd0);
    endtask

    // Sends stim_q (up to stop_after bytes). After each byte's accepting edge
    // it checks that a write appears exactly when that byte completed a word.
    task automatic play(input int gapped, input int stop_after);
        int n;
        int pay;
        int p;
        n   = int'({stim_q[1], stim_q[0]});
        pay = (n <= 256) ? 4 * n : 0;
        for (int i = 0; i < stim_q.size() && i < stop_after; i++) begin
            if (gapped != 0) begin
                int g;
                g = (i % 2 == 1) ? 1 : $urandom_range(0, 5);
                repeat (g) idle_in_load();
            end
            @(negedge clk);
            in_data  = stim_q[i];
            in_valid = 1'b1;
            check("byte_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            p = i - 2;
            if (p >= 0 && p < pay && (p % 4) == 3) begin
                check("wr_we", 32'(mem_write_enable), 32'd1);
                check("wr_addr", mem_byte_address, 32'(4 * (p / 4)));
                check("wr_data", mem_write_data, exp_q.pop_front());
            end else begin
                check("no_wr", 32'(mem_write_enable), 32'd0);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic load_good_frame(input logic [7:0] chk, input int gapped);
        stim_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h20, 8'h00};
        stim_q.push_back(chk);
        exp_q  = '{32'h0000_0013, 32'h0020_0093};
        play(gapped, 100);
    endtask

    task automatic expect_done(input string tag);
        check({tag, "_done"}, 32'(load_done), 32'd1);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_error"}, 32'(load_error), 32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_gone"}, 32'(load_done), 32'd0);
        check({tag, "_hold_after"}, 32'(cpu_hold), 32'd0);
        check({tag, "_we_after"}, 32'(mem_write_enable), 32'd0);
    endtask

    // Directed sequence
    initial begin
        reset_n    = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        #12;
        check_reset_vals("reset");
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        reset_n = 1'b1;

        // Stray bytes in IDLE are not accepted
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        check("idle_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("idle_we", 32'(mem_write_enable), 32'd0);
        in_valid = 1'b0;

        // 1: good frame, back-to-back
        load_pulse();
        load_good_frame(8'hA0, 0);
        check("t1_state", 32'(dbg_state), 32'(ST_DONE));
        expect_done("t1");

        // 2: bad checksum
        load_pulse();
        load_good_frame(8'hFF, 0);
        check("t2_error", 32'(load_error), 32'd1);
        check("t2_hold", 32'(cpu_hold), 32'd1);
        check("t2_done", 32'(load_done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t2_error_sticky", 32'(load_error), 32'd1);
        check("t2_ready", 32'(in_ready), 32'd0);
        load_pulse();

        // 3: N=257 exceeds capacity (continues the load started above)
        stim_q = '{8'h01, 8'h01};
        exp_q.delete();
        play(0, 100);
        check("t3_error", 32'(load_error), 32'd1);
        check("t3_ready", 32'(in_ready), 32'd0);
        check("t3_hold", 32'(cpu_hold), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("t3_no_wr", 32'(mem_write_enable), 32'd0);

        // 4: N=0
        load_pulse();
        stim_q = '{8'h00, 8'h00, 8'h00};
        play(0, 100);
        expect_done("t4");

        // 5: gapped stream
        load_pulse();
        load_good_frame(8'hA0, 1);
        expect_done("t5");

        // 6: reset after 6 payload bytes, then a full load
        load_pulse();
        stim_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h20, 8'h00, 8'hA0};
        exp_q  = '{32'h0000_0013, 32'h0020_0093};
        play(0, 8);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("t6_async");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t6_no_partial_wr", 32'(mem_write_enable), 32'd0);
        check("t6_idle", 32'(dbg_state), 32'(ST_IDLE));
        load_pulse();
        load_good_frame(8'hA0, 0);
        expect_done("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
